// File: rtl/rx_nrzi_destuff.sv
// USB RX bit decoder: NRZI decode, bit de-stuffing and LSB-first byte assembly.
// Optional macro RX_STUFF_CHECK_EN enables stuff_error generation on a bad stuffed bit.
module rx_nrzi_destuff #(
    parameter int STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       shift_enable,
    input  logic       rcv_active,
    output logic       d_orig,
    output logic       invalid_bit,
    output logic       eop,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       stuff_error
);
    localparam int OW = $clog2(STUFF_LEN + 1);

    logic          prev_level;
    logic [OW-1:0] ones_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic          se0_p0;
    logic          dbit_p0;
    logic [OW-1:0] ones_nxt_p0;

    // Run length of decoded ones after this bit; a zero restarts the run.
    function automatic logic [OW-1:0] next_ones(input logic [OW-1:0] cnt, input logic b);
        return b ? OW'(cnt + OW'(1)) : '0;
    endfunction

    // Stage p0: combinational decode of the strobed line state.
    assign se0_p0      = ~d_plus & ~d_minus;
    assign dbit_p0     = (d_plus == prev_level);
    assign ones_nxt_p0 = next_ones(ones_cnt, dbit_p0);

    // Stage p1: registered decoder state and outputs.
    always_ff @(posedge clk) begin
        eop         <= 1'b0;
        byte_valid  <= 1'b0;
        stuff_error <= 1'b0;
        if (!n_rst) begin
            prev_level  <= 1'b1;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            d_orig      <= 1'b1;
            invalid_bit <= 1'b0;
            rx_data     <= '0;
        end else if (!rcv_active) begin
            prev_level  <= 1'b1;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            d_orig      <= 1'b1;
            invalid_bit <= 1'b0;
        end else if (shift_enable) begin
            if (se0_p0) begin
                // SE0 overrides a pending stuff slot and drops any partial byte.
                eop         <= 1'b1;
                bit_cnt     <= '0;
                ones_cnt    <= '0;
                invalid_bit <= 1'b0;
                prev_level  <= 1'b1;
            end else begin
                prev_level <= d_plus;
                d_orig     <= dbit_p0;
                if (invalid_bit) begin
                    ones_cnt    <= '0;
                    invalid_bit <= 1'b0;
`ifdef RX_STUFF_CHECK_EN
                    stuff_error <= dbit_p0;
`endif
                end else begin
                    shreg    <= {dbit_p0, shreg[7:1]};
                    bit_cnt  <= 3'(bit_cnt + 3'd1);
                    ones_cnt <= ones_nxt_p0;
                    if (ones_nxt_p0 == OW'(STUFF_LEN))
                        invalid_bit <= 1'b1;
                    if (bit_cnt == 3'd7) begin
                        rx_data    <= {dbit_p0, shreg[7:1]};
                        byte_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_nrzi_destuff.sv
// Randomized and directed bench for rx_nrzi_destuff against a queue-based reference model.
module tb_rx_nrzi_destuff;
    localparam int STUFF_LEN = 6;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_plus = 1'b1;
    logic       d_minus = 1'b0;
    logic       shift_enable = 1'b0;
    logic       rcv_active = 1'b0;
    logic       d_orig;
    logic       invalid_bit;
    logic       eop;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic       stuff_error;

    int vectors = 0;
    int miscompares = 0;

    rx_nrzi_destuff #(.STUFF_LEN(STUFF_LEN)) dut (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus),
        .shift_enable(shift_enable), .rcv_active(rcv_active),
        .d_orig(d_orig), .invalid_bit(invalid_bit), .eop(eop),
        .rx_data(rx_data), .byte_valid(byte_valid), .stuff_error(stuff_error)
    );

    always #5 clk = ~clk;

    wire [12:0] dut_vec = {d_orig, invalid_bit, eop, byte_valid, stuff_error, rx_data};

    // Reference model: line level memory, ones-run length, pending stuff slot, bit queue.
    int   m_prev = 1;
    int   m_run = 0;
    bit   m_pend = 0;
    bit   m_bits[$];
    bit   m_dorig = 1, m_eop = 0, m_bv = 0, m_se = 0;
    logic [7:0] m_data = 8'h00;

    function automatic logic [12:0] exp_vec();
        return {m_dorig, m_pend, m_eop, m_bv, m_se, m_data};
    endfunction

    task automatic model_step(input bit n, input bit ra, input bit se, input bit dp, input bit dm);
        int b;
        m_eop = 0; m_bv = 0; m_se = 0;
        if (!n || !ra) begin
            m_prev = 1; m_run = 0; m_pend = 0; m_bits.delete(); m_dorig = 1;
            if (!n) m_data = 8'h00;
        end else if (se) begin
            if (!dp && !dm) begin
                m_eop = 1; m_bits.delete(); m_run = 0; m_pend = 0; m_prev = 1;
            end else begin
                b = (dp == m_prev) ? 1 : 0;
                m_prev = dp;
                m_dorig = b[0];
                if (m_pend) begin
                    m_pend = 0;
                    m_run = 0;
`ifdef RX_STUFF_CHECK_EN
                    m_se = b[0];
`endif
                end else begin
                    m_bits.push_back(b[0]);
                    m_run = b ? m_run + 1 : 0;
                    if (m_run == STUFF_LEN) m_pend = 1;
                    if (m_bits.size() == 8) begin
                        int v = 0;
                        for (int i = 0; i < 8; i++) v += int'(m_bits[i]) << i;
                        m_data = v[7:0];
                        m_bv = 1;
                        m_bits.delete();
                    end
                end
            end
        end
    endtask

    task automatic step(input bit n, input bit ra, input bit se, input bit dp, input bit dm);
        n_rst = n; rcv_active = ra; shift_enable = se; d_plus = dp; d_minus = dm;
        model_step(n, ra, se, dp, dm);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1);
        vectors++;
        if (dut_vec !== 13'h1000) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", dut_vec, 13'h1000);
        end
        step(1, 1, 0, 1, 0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_sync_byte();
        bit lv[8] = '{0, 1, 0, 1, 0, 1, 0, 0};
        int bv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, lv[i], ~lv[i]);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL sync_byte bit %0d got %h want %h", i, dut_vec, exp_vec());
            end
            bv_seen += int'(byte_valid);
        end
        vectors++;
        if (rx_data !== 8'h80 || bv_seen != 1) begin
            miscompares++;
            $display("FAIL sync_value rx_data %h bv %0d want 80 bv 1", rx_data, bv_seen);
        end
    endtask

    task automatic test_stuffing();
        bit lv[9] = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
        logic [3:0] inv_trace = '0;
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 1, lv[i], ~lv[i]);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stuffing bit %0d got %h want %h", i, dut_vec, exp_vec());
            end
            if (i >= 5 && i <= 8) inv_trace[i-5] = invalid_bit | (stuff_error << 0) & 1'b0;
            if (i == 6 && stuff_error !== 1'b0) begin
                miscompares++;
                $display("FAIL stuff_no_err got %b want 0", stuff_error);
            end
        end
        vectors++;
        if (inv_trace !== 4'b0001 || rx_data !== 8'h7F || byte_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stuff_byte inv %b rx %h bv %b want 0001 7f 1", inv_trace, rx_data, byte_valid);
        end
    endtask

    task automatic test_stuff_violation();
        int inv_ones = -1;
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 13; i++) begin
            step(1, 1, 1, 1'b1, 1'b0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stuff_viol strobe %0d got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 6) begin
                vectors++;
`ifdef RX_STUFF_CHECK_EN
                if (stuff_error !== 1'b1) begin
`else
                if (stuff_error !== 1'b0) begin
`endif
                    miscompares++;
                    $display("FAIL stuff_err_pulse got %b", stuff_error);
                end
            end
            if (i > 6 && invalid_bit === 1'b1 && inv_ones < 0) inv_ones = i - 6;
        end
        vectors++;
        if (inv_ones != 6) begin
            miscompares++;
            $display("FAIL ones_restart got %0d want 6", inv_ones);
        end
    endtask

    task automatic test_eop_mid_byte();
        bit lv[8] = '{0, 1, 0, 1, 0, 1, 0, 0};
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, lv[i], ~lv[i]);
        step(1, 1, 1, 0, 0);
        vectors++;
        if (eop !== 1'b1 || byte_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL eop_pulse got %h want %h", dut_vec, exp_vec());
        end
        step(1, 1, 0, 1, 0);
        vectors++;
        if (eop !== 1'b0) begin
            miscompares++;
            $display("FAIL eop_one_cycle got %b want 0", eop);
        end
        for (int i = 0; i < 8; i++) step(1, 1, 1, lv[i], ~lv[i]);
        vectors++;
        if (rx_data !== 8'h80 || byte_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL eop_resync rx %h bv %b want 80 1", rx_data, byte_valid);
        end
    endtask

    task automatic test_reset_mid_byte();
        bit lv[8] = '{0, 1, 0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 4; i++) step(1, 1, 1, lv[i], ~lv[i]);
        step(0, 1, 1, 0, 1);
        vectors++;
        if (dut_vec !== 13'h1000) begin
            miscompares++;
            $display("FAIL reset_mid got %h want %h", dut_vec, 13'h1000);
        end
        for (int i = 0; i < 8; i++) step(1, 1, 1, lv[i], ~lv[i]);
        vectors++;
        if (rx_data !== 8'h80 || byte_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_refill rx %h bv %b want 80 1", rx_data, byte_valid);
        end
    endtask

    task automatic test_rcv_inactive();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            vectors++;
            if (dut_vec !== 13'h1080) begin
                miscompares++;
                $display("FAIL rcv_idle cycle %0d got %h want %h", i, dut_vec, 13'h1080);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit dp = 1;
        for (int i = 0; i < 3000; i++) begin
            bit n  = ($urandom_range(0, 199) != 0);
            bit ra = ($urandom_range(0, 49) != 0);
            bit se = ($urandom_range(0, 3) != 0);
            bit dm;
            if ($urandom_range(0, 2) == 0) dp = ~dp;
            dm = ~dp;
            if ($urandom_range(0, 59) == 0) begin dp = 0; dm = 0; end
            else if ($urandom_range(0, 99) == 0) dm = 1;
            step(n, ra, se, dp, dm);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sync_byte();
        test_stuffing();
        test_stuff_violation();
        test_eop_mid_byte();
        test_reset_mid_byte();
        test_rcv_inactive();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
